dds_phase_acc: RTL and testbench

DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

---
 rtl/dds_phase_acc.sv | 57 +++++
 tb/tb_dds_phase_acc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: adds a tuning word on every enabled cycle and wraps modulo 2^PHASE_ACC_WIDTH.
// A registered carry pulses on each wrap.
module dds_phase_acc #(
    parameter int             PHASE_INC_WIDTH = 16,
    parameter int             PHASE_ACC_WIDTH = 16,
    parameter longint unsigned PHASE_INITIAL  = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PHASE_INC_WIDTH-1:0] phase_inc_i,
    input  logic                       phase_inc_ena_i,
    input  logic [PHASE_ACC_WIDTH-1:0] phase_load_i,
    input  logic                       phase_load_ena_i,
    output logic [PHASE_ACC_WIDTH-1:0] phase_acc_o,
    output logic                       phase_acc_carry_o
);

    generate
        if (PHASE_INC_WIDTH < 1 || PHASE_ACC_WIDTH < 1 || PHASE_INC_WIDTH > PHASE_ACC_WIDTH) begin : g_bad_width
            $error("dds_phase_acc: PHASE_INC_WIDTH must be in 1..PHASE_ACC_WIDTH");
        end
    endgenerate

    localparam logic [PHASE_ACC_WIDTH-1:0] ACC_INIT = PHASE_ACC_WIDTH'(PHASE_INITIAL);

    logic [PHASE_ACC_WIDTH-1:0] acc_q, acc_d;
    logic                       carry_q, carry_d;
    logic [PHASE_ACC_WIDTH:0]   sum;

    // One extra bit on the adder captures the wrap.
    assign sum = {1'b0, acc_q} + (PHASE_ACC_WIDTH + 1)'(phase_inc_i);

    always_comb begin
        acc_d   = acc_q;
        carry_d = 1'b0;
        if (phase_load_ena_i) begin
            acc_d = phase_load_i;
        end else if (phase_inc_ena_i) begin
            acc_d   = sum[PHASE_ACC_WIDTH-1:0];
            carry_d = sum[PHASE_ACC_WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= ACC_INIT;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign phase_acc_o       = acc_q;
    assign phase_acc_carry_o = carry_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// Directed bench for dds_phase_acc: one instance with PHASE_INITIAL = 0, one with 0x8000.
module tb_dds_phase_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] phase_inc;
    logic        phase_inc_ena;
    logic [15:0] phase_load;
    logic        phase_load_ena;
    logic [15:0] acc0, acc8;
    logic        carry0, carry8;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    dds_phase_acc #(.PHASE_INC_WIDTH(16), .PHASE_ACC_WIDTH(16), .PHASE_INITIAL(0)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .phase_inc_i      (phase_inc),
        .phase_inc_ena_i  (phase_inc_ena),
        .phase_load_i     (phase_load),
        .phase_load_ena_i (phase_load_ena),
        .phase_acc_o      (acc0),
        .phase_acc_carry_o(carry0)
    );

    dds_phase_acc #(.PHASE_INC_WIDTH(16), .PHASE_ACC_WIDTH(16), .PHASE_INITIAL(64'h8000)) dut_init (
        .clk_i            (clk),
        .rst_i            (rst),
        .phase_inc_i      (phase_inc),
        .phase_inc_ena_i  (phase_inc_ena),
        .phase_load_i     (phase_load),
        .phase_load_ena_i (phase_load_ena),
        .phase_acc_o      (acc8),
        .phase_acc_carry_o(carry8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ld_ena, input logic [15:0] ld,
                                 input logic in_ena, input logic [15:0] inc);
        rst            = r;
        phase_load_ena = ld_ena;
        phase_load     = ld;
        phase_inc_ena  = in_ena;
        phase_inc      = inc;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [15:0] exp_acc;
        applyStimulus(1'b1, 1'b1, 16'h0123, 1'b1, 16'h0FFF);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("reset_acc", acc0, 16'h0000);
            checkOutput("reset_carry", carry0, 1'b0);
            checkOutput("reset_acc_init", acc8, 16'h8000);
            checkOutput("reset_carry_init", carry8, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 16'hDEAD, 1'b0, 16'hBEEF);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("hold_acc", acc0, 16'h0000);
            checkOutput("hold_carry", carry0, 1'b0);
            checkOutput("hold_acc_init", acc8, 16'h8000);
            checkOutput("hold_carry_init", carry8, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080);
        for (int i = 1; i <= 513; i++) begin
            step();
            exp_acc = 16'(i * 128);
            if (i == 150) checkOutput("inc150_acc", acc0, 16'h4B00);
            if (i == 512) checkOutput("inc512_acc", acc0, 16'h0000);
            checkOutput("inc_acc", acc0, exp_acc);
            checkOutput("inc_carry", carry0, (i == 512) ? 1'b1 : 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 16'h0123, 1'b0, 16'h0FFF);
        step();
        checkOutput("load_acc", acc0, 16'h0123);
        checkOutput("load_carry", carry0, 1'b0);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0FFF);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 1)  checkOutput("wrap1_acc", acc0, 16'h1122);
            if (i == 15) checkOutput("wrap15_acc", acc0, 16'hF114);
            if (i == 16) checkOutput("wrap16_acc", acc0, 16'h0113);
            if (i == 17) checkOutput("wrap17_acc", acc0, 16'h1112);
            checkOutput("wrap_carry", carry0, (i == 16) ? 1'b1 : 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 16'h0123, 1'b1, 16'h0FFF);
        step();
        checkOutput("prio_load_acc", acc0, 16'h0123);
        checkOutput("prio_load_carry", carry0, 1'b0);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
        step();
        checkOutput("inc_zero_acc", acc0, 16'h0123);
        checkOutput("inc_zero_carry", carry0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'hFF00, 1'b0, 16'h0000);
        step();
        checkOutput("exact_load_acc", acc0, 16'hFF00);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100);
        step();
        checkOutput("exact_wrap_acc", acc0, 16'h0000);
        checkOutput("exact_wrap_carry", carry0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0100);
        step();
        checkOutput("post_wrap_hold_acc", acc0, 16'h0000);
        checkOutput("post_wrap_hold_carry", carry0, 1'b0);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080);
        step();
        checkOutput("pre_rst_acc", acc0, 16'h0080);
        applyStimulus(1'b1, 1'b1, 16'h0123, 1'b1, 16'h0FFF);
        step();
        checkOutput("prio_rst_acc", acc0, 16'h0000);
        checkOutput("prio_rst_carry", carry0, 1'b0);
        checkOutput("prio_rst_acc_init", acc8, 16'h8000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080);
        step();
        checkOutput("resume_acc", acc0, 16'h0080);
        checkOutput("resume_acc_init", acc8, 16'h8080);
        checkOutput("resume_carry_init", carry8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
